filter_scale_sequencer: RTL and testbench

Closed-loop sequencer for the moving-average filter auto-scale path.
- Periodically issues UPDATE requests to the auto-scale datapath.
- Collects the resulting amplitude estimate and filters scale decisions through a consecutive-vote hysteresis.
- Applies one-step scale changes to the filter DELAY, then blanks filter output validity while the filter refills.
- Sits between the moving_avg_filter / autoscale datapath and the downstream phase/frequency consumer.

---
 rtl/filter_scale_sequencer_pkg.sv | 29 ++
 rtl/filter_scale_sequencer_vote.sv | 72 +++++++
 rtl/filter_scale_sequencer.sv | 158 +++++++++++++++
 tb/tb_filter_scale_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_scale_sequencer_pkg.sv
// Shared encodings for the moving-average filter auto-scale sequencer.
// Holds the FSM states, vote values, SCALE_STEP codes and a counter-width helper.
package filter_scale_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_AMP = 2'd1,
      ST_DECIDE   = 2'd2,
      ST_SETTLE   = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      VOTE_NONE = 2'd0,
      VOTE_UP   = 2'd1,
      VOTE_DOWN = 2'd2
   } vote_e;

   typedef enum logic [1:0] {
      STEP_NONE = 2'b00,
      STEP_UP   = 2'b01,
      STEP_DOWN = 2'b10
   } step_e;

   // Bits needed to hold the values 0..max_val.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/filter_scale_sequencer_vote.sv
// Consecutive-vote hysteresis: classifies an amplitude estimate and decides
// whether a saturating one-step scale change is due.
module scale_vote_hysteresis
   import filter_scale_sequencer_pkg::*;
#(
   parameter int unsigned AMP_BITS    = 3,
   parameter int unsigned SCALE_BITS  = 3,
   parameter int unsigned VOTES       = 3,
   parameter int unsigned LOW_THRESH  = 3,
   parameter int unsigned HIGH_THRESH = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic [AMP_BITS-1:0]   amp,
   input  logic [SCALE_BITS-1:0] scale,
   output step_e                 step_c
);

   localparam int unsigned CNT_W = cnt_width(VOTES);
   localparam logic [SCALE_BITS-1:0] SCALE_MAX = '1;

   vote_e            last_vote;
   vote_e            last_vote_n;
   vote_e            vote_c;
   logic [CNT_W-1:0] vote_cnt;
   logic [CNT_W-1:0] vote_cnt_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         last_vote <= VOTE_NONE;
         vote_cnt  <= '0;
      end else if (en) begin
         last_vote <= last_vote_n;
         vote_cnt  <= vote_cnt_n;
      end
   end

   // Vote classification, streak counting and saturating step decision.
   always_comb begin
      vote_c      = VOTE_NONE;
      vote_cnt_n  = vote_cnt;
      step_c      = STEP_NONE;
      if (32'(amp) < LOW_THRESH) begin
         vote_c = VOTE_UP;
      end else if (32'(amp) >= HIGH_THRESH) begin
         vote_c = VOTE_DOWN;
      end
      last_vote_n = vote_c;

      if (vote_c == VOTE_NONE) begin
         vote_cnt_n = '0;
      end else if (vote_c == last_vote) begin
         if (vote_cnt < CNT_W'(VOTES)) begin
            vote_cnt_n = vote_cnt + CNT_W'(1);
         end
      end else begin
         vote_cnt_n = CNT_W'(1);
      end

      // A completed streak always clears, even when the scale is pinned.
      if ((vote_c != VOTE_NONE) && (vote_cnt_n == CNT_W'(VOTES))) begin
         vote_cnt_n = '0;
         if ((vote_c == VOTE_UP) && (scale != SCALE_MAX)) begin
            step_c = STEP_UP;
         end else if ((vote_c == VOTE_DOWN) && (scale != '0)) begin
            step_c = STEP_DOWN;
         end
      end
   end

endmodule

// File: rtl/filter_scale_sequencer.sv
// Closed-loop sequencer for the moving-average filter auto-scale path: periodic
// UPDATE requests, amplitude collection, vote-filtered DELAY steps and refill blanking.
module filter_scale_sequencer
   import filter_scale_sequencer_pkg::*;
#(
   parameter int unsigned DELAY_BITS    = 4,
   parameter int unsigned AMP_BITS      = 3,
   parameter int unsigned UPDATE_PERIOD = 200,
   parameter int unsigned VOTES         = 3,
   parameter int unsigned LOW_THRESH    = 3,
   parameter int unsigned HIGH_THRESH   = 6,
   parameter int unsigned REQ_TIMEOUT   = 8,
   parameter int unsigned SCALE_INIT    = 0
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  CE,
   input  logic [AMP_BITS-1:0]   AMP,
   input  logic                  AMP_VALID,
   output logic                  UPDATE,
   output logic [DELAY_BITS-1:0] DELAY,
   output logic                  OUT_VALID,
   output logic [1:0]            SCALE_STEP,
   output logic                  TIMEOUT_ERR
);

   localparam int unsigned SCALE_W = DELAY_BITS - 1;
   localparam int unsigned PER_W   = cnt_width(UPDATE_PERIOD - 1);
   localparam int unsigned TO_W    = cnt_width(REQ_TIMEOUT - 1);
   localparam int unsigned SET_W   = DELAY_BITS + 2;

   state_e              state,      state_n;
   logic [PER_W-1:0]    period_cnt, period_n;
   logic [TO_W-1:0]     to_cnt,     to_n;
   logic [SET_W-1:0]    settle_cnt, settle_n;
   logic [SCALE_W-1:0]  scale,      scale_n;
   logic [AMP_BITS-1:0] amp_q,      amp_n;
   logic                update_q,   update_n;
   logic                out_valid_q, out_valid_n;
   logic                to_err_q,   to_err_n;
   step_e               step_q,     step_n;
   step_e               step_c;
   logic [SET_W-1:0]    delay_ext_c;
   logic [SET_W-1:0]    settle_last_c;

   scale_vote_hysteresis #(
      .AMP_BITS    (AMP_BITS),
      .SCALE_BITS  (SCALE_W),
      .VOTES       (VOTES),
      .LOW_THRESH  (LOW_THRESH),
      .HIGH_THRESH (HIGH_THRESH)
   ) u_vote (
      .clk    (CLK),
      .reset  (RESET),
      .en     (CE && (state == ST_DECIDE)),
      .amp    (amp_q),
      .scale  (scale),
      .step_c (step_c)
   );

   // Refill time is 2*(DELAY+1) CE cycles, derived from the already-updated scale.
   assign delay_ext_c   = SET_W'({scale, 1'b1});
   assign settle_last_c = ((delay_ext_c + SET_W'(1)) << 1) - SET_W'(1);

   assign UPDATE      = update_q;
   assign DELAY       = {scale, 1'b1};
   assign OUT_VALID   = out_valid_q;
   assign SCALE_STEP  = step_q;
   assign TIMEOUT_ERR = to_err_q;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state       <= ST_IDLE;
         period_cnt  <= '0;
         to_cnt      <= '0;
         settle_cnt  <= '0;
         scale       <= SCALE_W'(SCALE_INIT);
         amp_q       <= '0;
         update_q    <= 1'b0;
         out_valid_q <= 1'b1;
         to_err_q    <= 1'b0;
         step_q      <= STEP_NONE;
      end else begin
         state       <= state_n;
         period_cnt  <= period_n;
         to_cnt      <= to_n;
         settle_cnt  <= settle_n;
         scale       <= scale_n;
         amp_q       <= amp_n;
         update_q    <= update_n;
         out_valid_q <= out_valid_n;
         to_err_q    <= to_err_n;
         step_q      <= step_n;
      end
   end

   // Next-state logic; with CE low everything holds and pulses drop.
   always_comb begin
      state_n     = state;
      period_n    = period_cnt;
      to_n        = to_cnt;
      settle_n    = settle_cnt;
      scale_n     = scale;
      amp_n       = amp_q;
      out_valid_n = out_valid_q;
      update_n    = 1'b0;
      to_err_n    = 1'b0;
      step_n      = STEP_NONE;

      if (CE) begin
         case (state)
            ST_IDLE: begin
               if (period_cnt == PER_W'(UPDATE_PERIOD - 1)) begin
                  period_n = '0;
                  to_n     = '0;
                  update_n = 1'b1;
                  state_n  = ST_WAIT_AMP;
               end else begin
                  period_n = period_cnt + PER_W'(1);
               end
            end
            ST_WAIT_AMP: begin
               if (AMP_VALID) begin
                  amp_n   = AMP;
                  state_n = ST_DECIDE;
               end else if (to_cnt == TO_W'(REQ_TIMEOUT - 1)) begin
                  to_err_n = 1'b1;
                  state_n  = ST_IDLE;
               end else begin
                  to_n = to_cnt + TO_W'(1);
               end
            end
            ST_DECIDE: begin
               state_n = ST_IDLE;
               if (step_c != STEP_NONE) begin
                  scale_n     = (step_c == STEP_UP) ? scale + SCALE_W'(1)
                                                    : scale - SCALE_W'(1);
                  step_n      = step_c;
                  out_valid_n = 1'b0;
                  settle_n    = '0;
                  state_n     = ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               period_n = '0;
               if (settle_cnt == settle_last_c) begin
                  out_valid_n = 1'b1;
                  state_n     = ST_IDLE;
               end else begin
                  settle_n = settle_cnt + SET_W'(1);
               end
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_filter_scale_sequencer.sv
// Randomized bench for filter_scale_sequencer: acts as the autoscale datapath and
// predicts every output from a transaction-level model of the scaling rules.
module tb_filter_scale_sequencer;

   localparam int unsigned DB = 4;
   localparam int unsigned AB = 3;
   localparam int unsigned PERIOD = 16;
   localparam int unsigned NV = 3;
   localparam int unsigned LT = 3;
   localparam int unsigned HT = 6;
   localparam int unsigned RT = 8;
   localparam int unsigned SI = 0;
   localparam int SCALE_MAX = (1 << (DB - 1)) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          ce;
   logic [AB-1:0] amp;
   logic          amp_valid;
   logic          update;
   logic [DB-1:0] delay;
   logic          out_valid;
   logic [1:0]    scale_step;
   logic          timeout_err;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference state: current scale, expected OUT_VALID, and the running vote streak.
   int m_scale;
   int m_ov;
   int streak_q[$];

   always #5 clk = ~clk;

   filter_scale_sequencer #(
      .DELAY_BITS    (DB),
      .AMP_BITS      (AB),
      .UPDATE_PERIOD (PERIOD),
      .VOTES         (NV),
      .LOW_THRESH    (LT),
      .HIGH_THRESH   (HT),
      .REQ_TIMEOUT   (RT),
      .SCALE_INIT    (SI)
   ) dut (
      .CLK         (clk),
      .RESET       (reset),
      .CE          (ce),
      .AMP         (amp),
      .AMP_VALID   (amp_valid),
      .UPDATE      (update),
      .DELAY       (delay),
      .OUT_VALID   (out_valid),
      .SCALE_STEP  (scale_step),
      .TIMEOUT_ERR (timeout_err)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
   endtask

   function automatic int vote_of(input int a);
      if (a < int'(LT)) return 1;
      if (a >= int'(HT)) return 2;
      return 0;
   endfunction

   // One CE=1 edge, optionally preceded by a few CE=0 edges that must change nothing.
   task automatic ce_edge(input logic av, input logic [AB-1:0] a);
      int n_idle;
      n_idle = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      for (int i = 0; i < n_idle; i++) begin
         ce        = 1'b0;
         amp_valid = 1'($urandom_range(0, 1));
         amp       = AB'($urandom);
         @(posedge clk); #1;
         check("ce0_update", int'(update), 0);
         check("ce0_step", int'(scale_step), 0);
         check("ce0_err", int'(timeout_err), 0);
         check("ce0_delay", int'(delay), 2 * m_scale + 1);
         check("ce0_ov", int'(out_valid), m_ov);
      end
      ce        = 1'b1;
      amp_valid = av;
      amp       = a;
      @(posedge clk); #1;
   endtask

   task automatic idle_round();
      for (int i = 0; i < int'(PERIOD); i++) begin
         ce_edge(1'($urandom_range(0, 5) == 0), AB'($urandom));
         check("update", int'(update), (i == int'(PERIOD) - 1) ? 1 : 0);
         check("idle_err", int'(timeout_err), 0);
         check("idle_step", int'(scale_step), 0);
         check("idle_ov", int'(out_valid), 1);
         check("idle_delay", int'(delay), 2 * m_scale + 1);
      end
   endtask

   task automatic apply_reset();
      ce        = 1'($urandom_range(0, 1));
      amp_valid = 1'b0;
      reset     = 1'b1;
      @(posedge clk); #1;
      reset    = 1'b0;
      m_scale  = SI;
      m_ov     = 1;
      streak_q.delete();
      check("rst_ov", int'(out_valid), 1);
      check("rst_delay", int'(delay), 2 * int'(SI) + 1);
      check("rst_update", int'(update), 0);
      check("rst_step", int'(scale_step), 0);
      check("rst_err", int'(timeout_err), 0);
   endtask

   // Answer (or ignore) one UPDATE, then check the decision and any refill window.
   task automatic answer_round(input int amp_v, input bit force_ans, input bit do_reset,
                               output bit reset_done);
      int k;
      int v;
      int exp_step;
      int n;
      bit got_it;
      reset_done = 1'b0;
      got_it     = 1'b0;
      k = force_ans ? int'($urandom_range(1, RT)) : int'($urandom_range(1, RT + 1));
      for (int j = 1; j <= int'(RT); j++) begin
         ce_edge(1'(j == k), (j == k) ? AB'(amp_v) : AB'($urandom));
         check("wait_update", int'(update), 0);
         check("wait_ov", int'(out_valid), 1);
         if (j == k) begin
            check("accept_no_err", int'(timeout_err), 0);
            got_it = 1'b1;
            break;
         end
         check("timeout", int'(timeout_err), (j == int'(RT)) ? 1 : 0);
      end
      if (!got_it) return;

      ce_edge(1'($urandom_range(0, 1)), AB'($urandom));
      v        = vote_of(amp_v);
      exp_step = 0;
      if (v == 0) begin
         streak_q.delete();
      end else begin
         if (streak_q.size() > 0 && streak_q[$] != v) streak_q.delete();
         streak_q.push_back(v);
         if (streak_q.size() == int'(NV)) begin
            streak_q.delete();
            if (v == 1 && m_scale < SCALE_MAX) begin
               m_scale++;
               exp_step = 1;
            end else if (v == 2 && m_scale > 0) begin
               m_scale--;
               exp_step = 2;
            end
         end
      end
      check("scale_step", int'(scale_step), exp_step);
      check("step_delay", int'(delay), 2 * m_scale + 1);
      check("step_ov", int'(out_valid), (exp_step != 0) ? 0 : 1);
      if (exp_step == 0) return;

      m_ov = 0;
      n    = 2 * ((2 * m_scale + 1) + 1);
      for (int s = 1; s <= n; s++) begin
         if (do_reset && s == n / 2) begin
            apply_reset();
            reset_done = 1'b1;
            return;
         end
         ce_edge(1'($urandom_range(0, 1)), AB'($urandom));
         check("settle_ov", int'(out_valid), (s == n) ? 1 : 0);
         check("settle_update", int'(update), 0);
         check("settle_step", int'(scale_step), 0);
         check("settle_delay", int'(delay), 2 * m_scale + 1);
         if (s == n) m_ov = 1;
      end
   endtask

   initial begin
      int dir_amps[11] = '{1, 1, 4, 1, 1, 1, 1, 1, 7, 7, 7};
      int a;
      bit rd;
      bit did_reset;

      reset     = 1'b1;
      ce        = 1'b0;
      amp_valid = 1'b0;
      amp       = '0;
      m_scale   = SI;
      m_ov      = 1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_update", int'(update), 0);
      check("reset_delay", int'(delay), 2 * int'(SI) + 1);
      check("reset_ov", int'(out_valid), 1);
      check("reset_step", int'(scale_step), 0);
      check("reset_err", int'(timeout_err), 0);
      reset = 1'b0;

      // Pure timeout round with no answer at all.
      idle_round();
      for (int j = 1; j <= int'(RT); j++) begin
         ce_edge(1'b0, AB'($urandom));
         check("first_timeout", int'(timeout_err), (j == int'(RT)) ? 1 : 0);
      end

      foreach (dir_amps[i]) begin
         idle_round();
         answer_round(dir_amps[i], 1'b1, 1'b0, rd);
      end

      for (int r = 0; r < 100; r++) begin
         if (r < 40)      a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 2));
         else if (r < 70) a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(6, 7));
         else             a = int'($urandom_range(0, 7));
         idle_round();
         answer_round(a, 1'b0, 1'b0, rd);
      end

      did_reset = 1'b0;
      for (int r = 0; r < 12 && !did_reset; r++) begin
         a = (m_scale == SCALE_MAX) ? 7 : 1;
         idle_round();
         answer_round(a, 1'b1, 1'b1, rd);
         did_reset = rd;
      end
      check("mid_settle_reset_seen", int'(did_reset), 1);

      idle_round();
      answer_round(1, 1'b1, 1'b0, rd);
      idle_round();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
